// File: rtl/sar_adc_pkg.sv
// Shared types, default parameters and helpers for the SAR ADC controller.
package sar_adc_pkg;

  // Conversion phases: idle, track/hold sampling, and one bit trial per settle window.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_BIT    = 2'd2
  } sar_state_t;

  localparam int SAR_N_BITS        = 8;
  localparam int SAR_SAMPLE_CYCLES = 4;
  localparam int SAR_SETTLE_CYCLES = 3;

  // Width needed to count 0..max_count-1 (at least one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability time before q is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: track/hold sequencing, binary search on
// the capacitive DAC code, and a valid/ack result port with sticky overrun.
//
// Handshake: data_valid rises with each finished result and holds until a cycle
// where data_ack=1 and data_valid=1; that ack clears data_valid at the next edge.
// A result landing on the same edge as an ack keeps data_valid high with the new
// data; a result landing on an unacknowledged one sets overrun.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              cont,
  input  logic              comp_in,
  output logic              sample_o,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              overrun
);

  localparam int MAX_CNT = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = cnt_width(MAX_CNT);
  localparam int IW      = cnt_width(N_BITS);

  localparam logic [CW-1:0]     SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_TOP     = IW'(N_BITS - 1);
  localparam logic [N_BITS-1:0] TOP_BIT     = {1'b1, {(N_BITS-1){1'b0}}};

  // Parameter legality: the settle window must cover the 2-flop synchronizer.
  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("sar_adc_ctrl: SETTLE_CYCLES must be in 3..15");
  end
  if (SAMPLE_CYCLES < 1 || SAMPLE_CYCLES > 255) begin : g_bad_sample
    $error("sar_adc_ctrl: SAMPLE_CYCLES must be in 1..255");
  end

  sar_state_t        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     bit_idx;
  logic [N_BITS-1:0] sar;
  logic              comp_sync;

  logic [N_BITS-1:0] sar_dec;
  logic [N_BITS-1:0] next_mask;
  logic              trial_done;
  logic              result_now;

  sync2 u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_in),
    .q     (comp_sync)
  );

  // Decision for the current bit, and the trial bit for the next lower position.
  always_comb begin
    sar_dec          = sar;
    sar_dec[bit_idx] = comp_sync;
    next_mask        = '0;
    if (bit_idx != '0) next_mask[bit_idx - IW'(1)] = 1'b1;
    trial_done = (state == ST_BIT) && en && (cnt == SETTLE_LAST);
    result_now = trial_done && (bit_idx == '0);
  end

  // Phase sequencing; sample_o, busy and dac_code are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sar      <= '0;
      sample_o <= 1'b0;
      busy     <= 1'b0;
      dac_code <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && start) begin
            state    <= ST_SAMPLE;
            cnt      <= '0;
            sar      <= '0;
            sample_o <= 1'b1;
            busy     <= 1'b1;
            dac_code <= '0;
          end
        end
        ST_SAMPLE: begin
          if (!en) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sar      <= '0;
            sample_o <= 1'b0;
            busy     <= 1'b0;
            dac_code <= '0;
          end else if (cnt == SAMPLE_LAST) begin
            state    <= ST_BIT;
            cnt      <= '0;
            bit_idx  <= IDX_TOP;
            sample_o <= 1'b0;
            dac_code <= TOP_BIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_BIT: begin
          if (!en) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sar      <= '0;
            sample_o <= 1'b0;
            busy     <= 1'b0;
            dac_code <= '0;
          end else if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (bit_idx == '0) begin
              // Conversion complete: restart sampling at once in free-run mode.
              sar      <= '0;
              dac_code <= '0;
              if (cont) begin
                state    <= ST_SAMPLE;
                sample_o <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sar      <= sar_dec;
              bit_idx  <= bit_idx - IW'(1);
              dac_code <= sar_dec | next_mask;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          sample_o <= 1'b0;
          busy     <= 1'b0;
          dac_code <= '0;
        end
      endcase
    end
  end

  // Result register with valid/ack handshake and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (result_now) begin
      data_out   <= sar_dec;
      data_valid <= 1'b1;
      if (data_valid && !data_ack) overrun <= 1'b1;
    end else if (data_valid && data_ack) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
